// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
// The control unit owns every datapath select/enable; the datapath supplies opcode and memory status.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             ALUSrcA;
  logic             RegWrite;
  logic             RegDst;
  logic [1:0]       PCSource;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcB;
  logic             InstrDone;
  logic             IllegalOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  // Handshake: a memory access in FETCH/MEMRD/MEMWR completes on the edge where
  // MemRead/MemWrite and MemReady are both high; requests stay stable until then.
  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           InstrDone, IllegalOp, State, InstrCount
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           InstrDone, IllegalOp, State, InstrCount
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 cycles, waits on
// MemReady for memory states, flags illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
  parameter int         CNT_W    = 16,
  parameter bit         MEM_WAIT = 1'b1,
  parameter logic [5:0] OP_JUMP  = 6'b010000,
  parameter bit         ADDI_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_unit_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  state_t           state, state_nxt;
  logic             mem_rdy;
  logic [CNT_W-1:0] count;
  logic             unused_zero;

  // Branch resolution lives in the datapath, so Zero is not needed here.
  assign unused_zero = bus.Zero;
  assign mem_rdy     = MEM_WAIT ? bus.MemReady : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = S_FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.InstrDone   = 1'b0;
    bus.IllegalOp   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        // PC and IR only update on the completing cycle, never while waiting.
        bus.IRWrite = mem_rdy;
        bus.PCWrite = mem_rdy;
        state_nxt   = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) state_nxt = S_MEMADR;
        else if (bus.Opcode == OP_RTYPE)                state_nxt = S_EXEC;
        else if (bus.Opcode == OP_BEQ)                  state_nxt = S_BRANCH;
        else if (bus.Opcode == OP_JUMP)                 state_nxt = S_JUMP;
        else if (ADDI_EN && bus.Opcode == OP_ADDI)      state_nxt = S_ADDIEX;
        else begin
          bus.IllegalOp = 1'b1;
          bus.InstrDone = 1'b1;
          state_nxt     = S_FETCH;
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_nxt   = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_nxt   = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.MemtoReg  = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = mem_rdy;
        state_nxt     = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst    = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.InstrDone   = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite   = 1'b1;
        bus.PCSource  = 2'b10;
        bus.InstrDone = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_nxt   = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      // Unused encodings recover to FETCH with everything deasserted.
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (bus.InstrDone) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.State      = state;
  assign bus.InstrCount = count;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS control FSM that replaces the single-cycle decoder in the processor datapath. It sequences each instruction over 3–5 cycles and drives the multicycle datapath's mux selects, write enables and ALUOp from a registered state. It adds a memory-ready handshake for variable-latency memory, illegal-opcode detection, and an instruction-retired counter.

## Interface

Parameters:
- CNT_W, 16: width of InstrCount.
- MEM_WAIT, 1: 1 = honour MemReady; 0 = MemReady ignored and treated as 1.
- OP_JUMP, 6'b010000: jump opcode, matching the existing single-cycle unit.
- ADDI_EN, 1: 1 = opcode 6'b001000 (addi) is legal; 0 = it is illegal.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26]. Sampled only in DECODE.
- Zero  in  1  ALU zero flag. Unused by the FSM; PCWriteCond gating is done in the datapath.
- MemReady  in  1  memory access completes this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCSource, ALUOp, ALUSrcB  out  2 each  datapath selects.
- InstrDone  out  1  final cycle of an instruction.
- IllegalOp  out  1  unknown opcode in DECODE.
- State  out  4  current state, for debug.
- InstrCount  out  CNT_W  retired-instruction count.

## Operation

State encodings:
- IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6
- EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12
- Encodings 13–15 are unused; they must go to FETCH on the next edge with all outputs 0.

Control outputs are Moore (decoded from State only), except those marked "(MemReady)". Any output not listed for a state is 0.
- IDLE: all 0. Next state FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady (MemReady). Stays in FETCH until MemReady, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw 100011 / sw 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - OP_JUMP → JUMP
  - 001000 (if ADDI_EN) → ADDIEX
  - else IllegalOp=1, InstrDone=1, → FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw → MEMRD, sw → MEMWR.
  - The opcode is re-read here; IR is stable because IRWrite=0 outside FETCH.
- MEMRD: MemRead=1, IorD=1. Stays until MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1, InstrDone=MemReady (MemReady). Stays until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, RegWrite=1, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next FETCH.

Counter:
- InstrCount increments on each rising edge where InstrDone=1, including illegal opcodes.
- Wraps modulo 2^CNT_W with no saturation.

## Timing

- Reset: rst_n low forces State=IDLE and InstrCount=0 immediately (asynchronous). Every output is 0 while reset is held.
- Reset deasserted mid-instruction: the instruction is abandoned with no partial count. The first edge after release enters FETCH.
- Instruction latency with MemReady=1 every cycle, counted from FETCH entry to the last cycle inclusive:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Memory controls hold constant while waiting. PCWrite and IRWrite must not pulse during a FETCH wait.
- MemReady outside FETCH, MEMRD and MEMWR is ignored.
- Back-to-back instructions: FETCH follows the completing state with zero idle cycles.

## Test plan

- Reset, then hold MemReady=1 and Opcode=000000: State goes 0→1→2→7→8→1. RegWrite=1 and RegDst=1 in state 8 only; InstrCount=1 after the ALUWB edge.
- lw with MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD: 10 cycles total. IRWrite is high exactly once; MemWrite is never high.
- sw, beq, OP_JUMP each with MemReady=1 give 4, 3, 3 cycles respectively:
  - sw: MemWrite=1 for one cycle.
  - beq: PCWriteCond=1, PCSource=01.
  - jump: PCWrite=1, PCSource=10.
- Opcode 111111, and 001000 with ADDI_EN=0: IllegalOp=1 for one cycle in DECODE, then FETCH, and InstrCount increments.
- CNT_W=4, 17 jump instructions: InstrCount reads 1 after wrapping through 15→0.
- rst_n pulsed low mid-MEMRD between edges: all outputs 0 and InstrCount=0 immediately, and FETCH is entered on the first edge after release.
